// File: rtl/bcm_scheduler.sv
// BCM row/bit-plane scheduler for a 32x32 LED panel: shift, blank, latch and weighted display per row/plane.
// Optional macro BCM_BRIGHTNESS_EN adds brightness_i[3:0], which trims the oe_n-low part of every DISPLAY window.
module bcm_scheduler #(
    parameter int CDEPTH       = 4,
    parameter int ROW_BITS     = 4,
    parameter int BASE_ON      = 16,
    parameter int BLANK_CYCLES = 2,
    parameter int LATCH_CYCLES = 2,
    localparam int PW          = (CDEPTH > 1) ? $clog2(CDEPTH) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                shift_done_i,
    input  logic                swap_req_i,
`ifdef BCM_BRIGHTNESS_EN
    input  logic [3:0]          brightness_i,
`endif
    output logic                shift_req_o,
    output logic [ROW_BITS-1:0] row_addr_o,
    output logic [PW-1:0]       plane_o,
    output logic [ROW_BITS-1:0] rsel_o,
    output logic                latch_o,
    output logic                oe_n_o,
    output logic                frame_done_o,
    output logic                swap_ack_o,
    output logic [2:0]          state_o
);

    localparam int CW = $clog2(BASE_ON << CDEPTH);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [PW-1:0] PLANE_LAST = PW'(CDEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SHIFT     = 3'd1,
        S_BLANK     = 3'd2,
        S_LATCH     = 3'd3,
        S_DISPLAY   = 3'd4,
        S_FRAME_END = 3'd5
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [ROW_BITS-1:0] row_q;
    logic [PW-1:0]       plane_q;
    logic [ROW_BITS-1:0] row_addr_q;
    logic [PW-1:0]       plane_out_q;
    logic [ROW_BITS-1:0] rsel_q;
    logic                shift_req_q;
    logic                latch_q;
    logic                oe_n_q;
    logic                frame_done_q;
    logic                swap_ack_q;
    logic [31:0]         dur_d;

    // Full DISPLAY length of the plane currently being worked on.
    assign dur_d = 32'(BASE_ON) << plane_q;

`ifdef BCM_BRIGHTNESS_EN
    logic [31:0] on_len_q;
    logic [31:0] on_len_d;

    assign on_len_d = (dur_d * (32'(brightness_i) + 32'd1)) >> 4;
`endif

    // Every output is re-registered from the state it describes, so all panel
    // pins move together one cycle behind the state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            row_q        <= '0;
            plane_q      <= '0;
            row_addr_q   <= '0;
            plane_out_q  <= '0;
            rsel_q       <= '0;
            shift_req_q  <= 1'b0;
            latch_q      <= 1'b0;
            oe_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
            swap_ack_q   <= 1'b0;
`ifdef BCM_BRIGHTNESS_EN
            on_len_q     <= '0;
`endif
        end else begin
            row_addr_q   <= row_q;
            plane_out_q  <= plane_q;
            shift_req_q  <= 1'b0;
            latch_q      <= 1'b0;
            oe_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
            swap_ack_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (enable_i) begin
                        state_q <= S_SHIFT;
                        row_q   <= '0;
                        plane_q <= '0;
                        cnt_q   <= '0;
                    end
                end

                S_SHIFT: begin
                    shift_req_q <= 1'b1;
                    cnt_q       <= '0;
                    if (shift_done_i) begin
                        state_q <= S_BLANK;
                    end
                end

                S_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_LATCH;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_LATCH: begin
                    latch_q <= 1'b1;
                    rsel_q  <= row_q;
                    if (cnt_q == LATCH_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_DISPLAY;
`ifdef BCM_BRIGHTNESS_EN
                        on_len_q <= on_len_d;
`endif
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_DISPLAY: begin
`ifdef BCM_BRIGHTNESS_EN
                    // Dimmed windows keep their full length so refresh rate is unchanged.
                    oe_n_q <= (32'(cnt_q) >= on_len_q);
`else
                    oe_n_q <= 1'b0;
`endif
                    if (32'(cnt_q) == dur_d - 32'd1) begin
                        cnt_q <= '0;
                        if (plane_q != PLANE_LAST) begin
                            plane_q <= plane_q + PW'(1);
                            state_q <= S_SHIFT;
                        end else begin
                            plane_q <= '0;
                            if (&row_q) begin
                                row_q   <= '0;
                                state_q <= S_FRAME_END;
                            end else begin
                                row_q   <= row_q + ROW_BITS'(1);
                                state_q <= S_SHIFT;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_FRAME_END: begin
                    frame_done_q <= 1'b1;
                    swap_ack_q   <= swap_req_i;
                    state_q      <= enable_i ? S_SHIFT : S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign shift_req_o  = shift_req_q;
    assign row_addr_o   = row_addr_q;
    assign plane_o      = plane_out_q;
    assign rsel_o       = rsel_q;
    assign latch_o      = latch_q;
    assign oe_n_o       = oe_n_q;
    assign frame_done_o = frame_done_q;
    assign swap_ack_o   = swap_ack_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_bcm_scheduler.sv
// Bench for bcm_scheduler: random shifter latency, swap and brightness per frame,
// expected DISPLAY windows and frame ends queued per frame and matched by a negedge monitor.
`timescale 1ns/1ps
module tb_bcm_scheduler;
  localparam int CDEPTH       = 4;
  localparam int ROW_BITS     = 4;
  localparam int BASE_ON      = 16;
  localparam int BLANK_CYCLES = 2;
  localparam int LATCH_CYCLES = 2;
  localparam int NROWS        = 1 << ROW_BITS;
  localparam int W            = 24;

  logic                clk;
  logic                rst_n;
  logic                enable;
  logic                shift_done;
  logic                swap_req;
  logic [3:0]          brightness;
  logic                shift_req_o;
  logic [ROW_BITS-1:0] row_addr_o;
  logic [1:0]          plane_o;
  logic [ROW_BITS-1:0] rsel_o;
  logic                latch_o;
  logic                oe_n_o;
  logic                frame_done_o;
  logic                swap_ack_o;
  logic [2:0]          state_o;

  bcm_scheduler #(
    .CDEPTH(CDEPTH), .ROW_BITS(ROW_BITS), .BASE_ON(BASE_ON),
    .BLANK_CYCLES(BLANK_CYCLES), .LATCH_CYCLES(LATCH_CYCLES)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .enable_i(enable),
    .shift_done_i(shift_done),
    .swap_req_i(swap_req),
`ifdef BCM_BRIGHTNESS_EN
    .brightness_i(brightness),
`endif
    .shift_req_o(shift_req_o),
    .row_addr_o(row_addr_o),
    .plane_o(plane_o),
    .rsel_o(rsel_o),
    .latch_o(latch_o),
    .oe_n_o(oe_n_o),
    .frame_done_o(frame_done_o),
    .swap_ack_o(swap_ack_o),
    .state_o(state_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit mon_on = 1'b0;
  bit fixed_lat = 1'b1;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Expected brightness in effect (full on when the feature is not built).
  function automatic int eff_b();
`ifdef BCM_BRIGHTNESS_EN
    return int'(brightness);
`else
    return 15;
`endif
  endfunction

  // Reference model: rows ascend, planes ascend within a row, plane p displays BASE_ON<<p
  // cycles of which (dur*(b+1))/16 have oe_n low; a frame ends with one frame_done.
  task automatic push_entries(input bit swap, input int b, input int nwin, input bit with_end);
    int k;
    k = 0;
    for (int r = 0; r < NROWS; r++) begin
      for (int p = 0; p < CDEPTH; p++) begin
        if (k < nwin) begin
          int d;
          int on;
          d  = BASE_ON << p;
          on = (d * (b + 1)) / 16;
          exp_q.push_back({1'b0, 1'b0, 4'(r), 2'(p), 8'(on), 8'(d)});
          k++;
        end
      end
    end
    if (with_end) exp_q.push_back({1'b1, swap, 22'd0});
  endtask

  // ---------------- shifter model ----------------
  initial begin
    int lat;
    shift_done = 1'b0;
    forever begin
      @(negedge clk);
      if (shift_req_o === 1'b1) begin
        lat = fixed_lat ? 3 : int'($urandom_range(1, 5));
        repeat (lat - 1) @(negedge clk);
        shift_done = 1'b1;
        @(negedge clk);
        shift_done = 1'b0;
        while (shift_req_o === 1'b1) @(negedge clk);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int cyc = 0;
  bit in_win, gap_pending;
  int win_len, win_start, last_dur, quiet_run, latch_run, blank_seen;
  logic [ROW_BITS-1:0] win_row, prev_rsel;
  logic [1:0] win_plane;
  logic prev_oe, prev_latch, prev_sr, prev_fd;
  logic [W-1:0] e;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n || !mon_on) begin
      in_win = 0; gap_pending = 0; quiet_run = 0; latch_run = 0; blank_seen = 0;
      prev_oe = 1'b1; prev_latch = 1'b0; prev_sr = 1'b0; prev_fd = 1'b0; prev_rsel = '0;
    end else begin
      if (!oe_n_o) check("rsel_eq_row_addr", 32'(rsel_o), 32'(row_addr_o));
      if (!oe_n_o && !prev_oe) begin
        check("rsel_stable_oe_low", 32'(rsel_o), 32'(prev_rsel));
        check("latch_stable_oe_low", 32'(latch_o), 32'(prev_latch));
      end
      if (latch_o && !prev_latch) blank_seen = quiet_run;

      if (prev_oe && !oe_n_o) begin
        check("latch_cycles", 32'(latch_run), 32'(LATCH_CYCLES));
        check("blank_cycles", 32'(blank_seen), 32'(BLANK_CYCLES));
        in_win = 1; win_len = 1; win_start = cyc; win_row = rsel_o; win_plane = plane_o;
        gap_pending = 0;
      end else if (in_win && !oe_n_o) begin
        win_len++;
      end else if (in_win && oe_n_o) begin
        in_win = 0;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL window_unexpected row=%0d plane=%0d len=%0d t=%0t", win_row, win_plane, win_len, $time);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if ({2'b00, win_row, win_plane, 8'(win_len)} !== e[23:8]) begin
            failures++;
            $display("FAIL window got row=%0d plane=%0d len=%0d exp kind=%0d row=%0d plane=%0d len=%0d t=%0t",
                     win_row, win_plane, win_len, e[23], e[21:18], e[17:16], e[15:8], $time);
          end
          last_dur = int'(e[7:0]);
          gap_pending = 1;
        end
      end

      if (gap_pending && ((shift_req_o && !prev_sr) || frame_done_o)) begin
        check("display_duration", 32'(cyc - win_start), 32'(last_dur));
        gap_pending = 0;
      end

      if (frame_done_o) begin
        check("frame_done_single_pulse", 32'(prev_fd), 32'd0);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL frame_done_unexpected got=1 exp=0 t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("frame_done_order", 32'(e[23]), 32'd1);
          check("swap_ack", 32'(swap_ack_o), 32'(e[22]));
        end
      end
      if (swap_ack_o) check("swap_ack_only_with_frame_done", 32'(frame_done_o), 32'd1);

      if (latch_o) latch_run++; else latch_run = 0;
      if (!shift_req_o && !latch_o && oe_n_o) quiet_run++; else quiet_run = 0;
      prev_oe = oe_n_o; prev_latch = latch_o; prev_sr = shift_req_o;
      prev_fd = frame_done_o; prev_rsel = rsel_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_frame(input string name);
    int n;
    @(negedge clk);
    n = 1;
    while (frame_done_o !== 1'b1 && n < 9000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 9000) begin
      checks++; failures++;
      $display("FAIL %s_timeout got=no_frame_done exp=frame_done t=%0t", name, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_shift_req"}, 32'(shift_req_o), 32'd0);
    check({tag, "_row_addr"}, 32'(row_addr_o), 32'd0);
    check({tag, "_plane"}, 32'(plane_o), 32'd0);
    check({tag, "_rsel"}, 32'(rsel_o), 32'd0);
    check({tag, "_latch"}, 32'(latch_o), 32'd0);
    check({tag, "_oe_n"}, 32'(oe_n_o), 32'd1);
    check({tag, "_frame_done"}, 32'(frame_done_o), 32'd0);
    check({tag, "_swap_ack"}, 32'(swap_ack_o), 32'd0);
  endtask

  task automatic check_idle(input string name, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      check({name, "_oe_n"}, 32'(oe_n_o), 32'd1);
      check({name, "_shift_req"}, 32'(shift_req_o), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit sw;
    int n;
    rst_n = 1'b0; enable = 1'b0; swap_req = 1'b0; brightness = 4'd15;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    mon_on = 1'b1;
    check_idle("idle_no_enable", 5);

    // Frame 1: fixed 3-cycle shifter, swap requested, full brightness.
    swap_req = 1'b1;
    brightness = 4'd15;
    push_entries(1'b1, eff_b(), NROWS * CDEPTH, 1'b1);
    enable = 1'b1;
    @(negedge clk);
    check("start_latency_edge_n", 32'(shift_req_o), 32'd0);
    @(negedge clk);
    check("start_latency_edge_n1", 32'(shift_req_o), 32'd1);
    wait_frame("frame1");

    // Frame 2: random shifter latency, no swap, half brightness.
    fixed_lat = 1'b0;
    swap_req = 1'b0;
    brightness = 4'd7;
    push_entries(1'b0, eff_b(), NROWS * CDEPTH, 1'b1);
    wait_frame("frame2");

    // Frame 3: random swap, minimum brightness, enable dropped during row 5.
    sw = 1'($urandom_range(0, 1));
    swap_req = sw;
    brightness = 4'd0;
    push_entries(sw, eff_b(), NROWS * CDEPTH, 1'b1);
    n = 0;
    while (row_addr_o !== 4'd5 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 6000) begin
      checks++; failures++;
      $display("FAIL row5_timeout got=%0d exp=5 t=%0t", row_addr_o, $time);
    end
    enable = 1'b0;
    wait_frame("frame3_enable_drop");
    check_idle("idle_after_drop", 40);
    check("queue_empty_after_drop", 32'(exp_q.size()), 32'd0);

    // Reset asserted in the middle of row 0 plane 2 DISPLAY.
    swap_req = 1'($urandom_range(0, 1));
    brightness = 4'd15;
    push_entries(1'b0, eff_b(), 2, 1'b0);
    enable = 1'b1;
    n = 0;
    while (!(plane_o === 2'd2 && oe_n_o === 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL plane2_timeout got=%0d exp=2 t=%0t", plane_o, $time);
    end
    repeat (5) @(negedge clk);
    check("oe_low_before_reset", 32'(oe_n_o), 32'd0);
    check("queue_empty_before_reset", 32'(exp_q.size()), 32'd0);
    mon_on = 1'b0;
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check_reset_values("async_reset");
    repeat (3) @(negedge clk);
    check_reset_values("held_reset");
    rst_n = 1'b1;
    mon_on = 1'b1;

    // Frame 4: restart after reset, random brightness, swap, enable released early.
    swap_req = 1'b1;
    brightness = 4'($urandom_range(0, 15));
    push_entries(1'b1, eff_b(), NROWS * CDEPTH, 1'b1);
    enable = 1'b1;
    n = 0;
    while (shift_req_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("restart_shift_req", 32'(shift_req_o), 32'd1);
    check("restart_row", 32'(row_addr_o), 32'd0);
    check("restart_plane", 32'(plane_o), 32'd0);
    enable = 1'b0;
    wait_frame("frame4");
    check_idle("idle_final", 20);
    check("queue_empty_final", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcm_scheduler.md
# bcm_scheduler

Row/bit-plane scheduler for the 32x32 LED matrix. It implements binary-code-modulation (BCM) PWM by sequencing, for each row, one column shift per colour bit-plane. Each shift is followed by a blank, latch and weighted output-enable window, and planes finish within a row before the next row starts. It sits between the frame buffer/column shifter and the panel pins, and hands the frame controller a safe buffer-swap point at every frame boundary.

## Interface
- CDEPTH, 4: colour bits per channel, which is also the number of bit-planes.
- ROW_BITS, 4: row-select width; the panel has 2**ROW_BITS row pairs.
- BASE_ON, 16: display cycles for plane 0; plane p displays BASE_ON<<p cycles.
- BLANK_CYCLES, 2: oe_n-high cycles before the latch.
- LATCH_CYCLES, 2: latch-high cycles.

Ports:
- clk  in  1  board clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run request; sampled at IDLE and at FRAME_END.
- shift_done  in  1  column shifter finished the 32 columns of the requested row/plane.
- swap_req  in  1  controller has a new frame ready (level).
- shift_req  out  1  request shifter to load row_addr/plane.
- row_addr  out  ROW_BITS  row being shifted.
- plane  out  $clog2(CDEPTH)  bit-plane being shifted.
- rsel  out  ROW_BITS  panel row select (A-D).
- latch  out  1  panel latch.
- oe_n  out  1  panel output enable, active low.
- frame_done  out  1  one-cycle pulse at frame end.
- swap_ack  out  1  one-cycle pulse granting a buffer swap.

## Operation
- The scheduler has five states: IDLE, SHIFT, BLANK, LATCH, DISPLAY, plus FRAME_END.
- IDLE: moves to SHIFT when enable=1, with row_addr=0 and plane=0.
- SHIFT: shift_req=1 is held until shift_done is sampled high, then the FSM moves to BLANK. shift_done outside SHIFT is ignored.
- BLANK: oe_n=1 for BLANK_CYCLES, then LATCH.
- LATCH: on entry, rsel<=row_addr. latch=1 for LATCH_CYCLES, then DISPLAY.
- DISPLAY: oe_n=0 for BASE_ON<<plane cycles. On exit:
  - plane<CDEPTH-1: plane+1, go to SHIFT.
  - Otherwise plane<=0; if row_addr is not all-ones, row_addr+1 and go to SHIFT.
  - Otherwise row_addr<=0 and go to FRAME_END.
- FRAME_END: lasts one cycle.
  - frame_done=1.
  - swap_ack=1 iff swap_req=1 in the same cycle.
  - Next state is SHIFT if enable=1, else IDLE.
- Clearing enable mid-frame never truncates the frame; the frame completes first.
- Display counter width is $clog2(BASE_ON<<CDEPTH). It counts up from 0 and compares against the target duration minus 1. Row and plane counters wrap only via the transitions above.
- oe_n=1 in every state except DISPLAY. rsel and latch change only while oe_n=1.

## Timing
- All outputs are registered.
- Reset values: shift_req 0, row_addr 0, plane 0, rsel 0, latch 0, oe_n 1, frame_done 0, swap_ack 0; state IDLE.
- Asserting reset at any point forces the reset values immediately, without waiting for clk, including mid-DISPLAY. After release, the block resumes from IDLE.
- enable=1 sampled in IDLE at edge N gives shift_req=1 after edge N+1.
- shift_done=1 sampled at edge M gives shift_req=0 and oe_n=1 (BLANK) after M+1.
- Per row/plane, with shift latency S cycles: S+BLANK_CYCLES+LATCH_CYCLES+(BASE_ON<<plane) cycles.
- swap_ack coincides exactly with frame_done. The controller must swap buffers only on that pulse.

## Configuration
- BCM_BRIGHTNESS_EN defined: adds input brightness [3:0].
  - The value is sampled on DISPLAY entry.
  - oe_n=0 only for the first (dur*(brightness+1))>>4 cycles of DISPLAY, then 1 for the remainder.
  - Total DISPLAY duration is unchanged, so refresh rate is independent of brightness.
- BCM_BRIGHTNESS_EN undefined: the port is absent and oe_n=0 for all of DISPLAY.

## Test plan
- Release reset, enable=1, shifter answers 3 cycles after shift_req. Row 0 shows oe_n-low windows of 16, 32, 64 and 128 cycles for planes 0-3, each preceded by 2 blank and 2 latch cycles.
- Across a full frame: rsel equals row_addr throughout every DISPLAY. rsel and latch never toggle while oe_n=0. Rows run 0..15 with planes 0..3 per row.
- After row 15 plane 3, frame_done pulses once.
  - swap_req held at 1: swap_ack pulses in the same cycle.
  - swap_req at 0: no swap_ack.
  - In both cases the next frame starts at row 0.
- Drop enable during row 5: the frame completes through row 15 plane 3, frame_done pulses, the FSM goes to IDLE, and oe_n=1 and shift_req=0 are held.
- Assert reset mid-DISPLAY of plane 2: oe_n=1 and all outputs take reset values before the next clk edge. After release with enable=1, the scheduler restarts at row 0 plane 0.
- With BCM_BRIGHTNESS_EN:
  - brightness=7, plane 3: oe_n low 64 of 128 DISPLAY cycles.
  - brightness=15: low all 128 cycles.
  - brightness=0, plane 0: low 1 of 16 cycles.
